// File: rtl/gpio_ctrl.sv
// GPIO controller: direction/output registers with atomic set/clear/toggle, synchronised
// inputs, rise/fall edge capture with W1C status and interrupt. Optional GPIO_DEBOUNCE_EN filter.
module gpio_ctrl #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       addr,
   input  logic             we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam logic [3:0] A_DIR  = 4'd0;
   localparam logic [3:0] A_OUT  = 4'd1;
   localparam logic [3:0] A_IN   = 4'd2;
   localparam logic [3:0] A_SET  = 4'd3;
   localparam logic [3:0] A_CLR  = 4'd4;
   localparam logic [3:0] A_TGL  = 4'd5;
   localparam logic [3:0] A_EN   = 4'd6;
   localparam logic [3:0] A_RISE = 4'd7;
   localparam logic [3:0] A_FALL = 4'd8;
   localparam logic [3:0] A_STAT = 4'd9;
   localparam logic [3:0] A_DB   = 4'd10;

   logic [WIDTH-1:0] dir, out_q, in_v, prev, stat, irq_en, irq_rise, irq_fall;
   logic [WIDTH-1:0] wd, ev, w1c;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

   assign wd = wdata[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   logic [DB_W-1:0]        db_limit, db_cnt;
   logic [2:0][WIDTH-1:0]  hist;
   logic [WIDTH-1:0]       in_q, stable;
   logic                   tick;

   assign tick   = (db_cnt == db_limit);
   assign stable = ~(hist[0] ^ hist[1]) & ~(hist[1] ^ hist[2]);
   assign in_v   = in_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_limit <= '0;
         db_cnt   <= '0;
         hist     <= '0;
         in_q     <= '0;
      end else begin
         if (we && addr == A_DB) begin
            db_limit <= wdata[DB_W-1:0];
            db_cnt   <= '0;
         end else begin
            db_cnt <= tick ? '0 : db_cnt + 1'b1;
         end
         if (tick) hist <= {hist[1:0], sync_q[SYNC_STAGES-1]};
         // a pin only moves once its last three tick samples agree
         in_q <= (in_q & ~stable) | (hist[0] & stable);
      end
   end
`else
   assign in_v = sync_q[SYNC_STAGES-1];
`endif

   assign ev  = (in_v & ~prev & irq_rise) | (~in_v & prev & irq_fall);
   assign w1c = (we && addr == A_STAT) ? wd : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir      <= '0;
         out_q    <= '0;
         prev     <= '0;
         stat     <= '0;
         irq_en   <= '0;
         irq_rise <= '0;
         irq_fall <= '0;
         irq      <= 1'b0;
      end else begin
         prev <= in_v;
         irq  <= |(stat & irq_en);
         // new event wins over a simultaneous W1C
         stat <= (stat & ~w1c) | ev;
         if (we) begin
            case (addr)
               A_DIR:   dir      <= wd;
               A_OUT:   out_q    <= wd;
               A_SET:   out_q    <= out_q | wd;
               A_CLR:   out_q    <= out_q & ~wd;
               A_TGL:   out_q    <= out_q ^ wd;
               A_EN:    irq_en   <= wd;
               A_RISE:  irq_rise <= wd;
               A_FALL:  irq_fall <= wd;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         A_DIR:  rdata[WIDTH-1:0] = dir;
         A_OUT:  rdata[WIDTH-1:0] = out_q;
         A_IN:   rdata[WIDTH-1:0] = in_v;
         A_EN:   rdata[WIDTH-1:0] = irq_en;
         A_RISE: rdata[WIDTH-1:0] = irq_rise;
         A_FALL: rdata[WIDTH-1:0] = irq_fall;
         A_STAT: rdata[WIDTH-1:0] = stat;
`ifdef GPIO_DEBOUNCE_EN
         A_DB:   rdata[DB_W-1:0]  = db_limit;
`endif
         default: rdata = '0;
      endcase
   end

   assign gpio_o  = out_q;
   assign gpio_oe = dir;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: register-level reference model checked every cycle plus directed literals.
module tb_gpio_ctrl;
   localparam int S = 2;
`ifdef GPIO_DEBOUNCE_EN
   localparam int L = S + 4;  // sync + three DB_LIMIT=0 ticks + filter update
`else
   localparam int L = S;
`endif

   logic        clk = 1'b0, rst = 1'b0, we = 1'b0, irq;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0, rdata, gpio_i = '0, gpio_o, gpio_oe;
   int tests = 0, fails = 0;
   bit live = 0;

   gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(S), .DB_W(16)) dut (
      .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq));

   always #5 clk = ~clk;

   // reference model: state of the programmer-visible registers and the pad pipeline
   logic [31:0] m_dir, m_out, m_in, m_prev, m_stat, m_en, m_rise, m_fall, m_synced;
   logic [31:0] sync_old, ev, eq, m_s0, m_s1, m_s2;
   logic [15:0] m_dblim, m_cnt;
   logic        m_irq;
   logic [31:0] sq[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         {m_dir, m_out, m_in, m_prev, m_stat, m_en, m_rise, m_fall, m_synced} = '0;
         {m_s0, m_s1, m_s2} = '0;
         m_dblim = '0; m_cnt = '0; m_irq = 1'b0;
         sq.delete();
      end else begin
         sync_old = m_synced;
         sq.push_front(gpio_i);
         if (sq.size() > S) void'(sq.pop_back());
         m_synced = (sq.size() == S) ? sq[S-1] : 32'h0;
         ev = (m_in & ~m_prev & m_rise) | (~m_in & m_prev & m_fall);
         m_irq = |(m_stat & m_en);
         if (we && addr == 4'd9) m_stat = m_stat & ~wdata;
         m_stat = m_stat | ev;
         m_prev = m_in;
`ifdef GPIO_DEBOUNCE_EN
         eq = ~(m_s0 ^ m_s1) & ~(m_s1 ^ m_s2);
         m_in = (m_in & ~eq) | (m_s0 & eq);
         if (m_cnt == m_dblim) begin m_s2 = m_s1; m_s1 = m_s0; m_s0 = sync_old; end
         if (we && addr == 4'd10) begin m_dblim = wdata[15:0]; m_cnt = '0; end
         else m_cnt = (m_cnt == m_dblim) ? 16'h0 : m_cnt + 16'h1;
`else
         m_in = m_synced;
`endif
         if (we) case (addr)
            4'd0: m_dir  = wdata;
            4'd1: m_out  = wdata;
            4'd3: m_out  = m_out | wdata;
            4'd4: m_out  = m_out & ~wdata;
            4'd5: m_out  = m_out ^ wdata;
            4'd6: m_en   = wdata;
            4'd7: m_rise = wdata;
            4'd8: m_fall = wdata;
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] mread(input logic [3:0] a);
      case (a)
         4'd0: return m_dir;
         4'd1: return m_out;
         4'd2: return m_in;
         4'd6: return m_en;
         4'd7: return m_rise;
         4'd8: return m_fall;
         4'd9: return m_stat;
`ifdef GPIO_DEBOUNCE_EN
         4'd10: return {16'h0, m_dblim};
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (live && rst) begin
         chk("cyc rdata", rdata, mread(addr));
         chk("cyc gpio_o", gpio_o, m_out);
         chk("cyc gpio_oe", gpio_oe, m_dir);
         chk("cyc irq", {31'h0, irq}, {31'h0, m_irq});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      addr = a; we = 1'b1; wdata = d;
      step(1);
      we = 1'b0;
   endtask

   task automatic rchk(input string nm, input logic [3:0] a, input logic [31:0] e);
      addr = a;
      #1;
      chk(nm, rdata, e);
   endtask

   initial begin
      // T1 reset
      step(2);
      for (int a = 0; a < 16; a++) rchk("rst rd", a[3:0], 32'h0);
      chk("rst oe", gpio_oe, 32'h0);
      chk("rst o", gpio_o, 32'h0);
      chk("rst irq", {31'h0, irq}, 32'h0);
      step(1);
      rst = 1'b1; live = 1;
      step(1);
      rchk("post rst DIR", 4'd0, 32'h0);
      rchk("post rst STAT", 4'd9, 32'h0);

      // T2 atomic ops: F0 |0F =FF, &~30 =CF, ^81 =4E
      wr(4'd1, 32'h0000_00F0);
      wr(4'd3, 32'h0000_000F);
      rchk("T2 set", 4'd1, 32'h0000_00FF);
      wr(4'd4, 32'h0000_0030);
      rchk("T2 clr", 4'd1, 32'h0000_00CF);
      wr(4'd5, 32'h0000_0081);
      rchk("T2 tgl", 4'd1, 32'h0000_004E);
      chk("T2 gpio_o", gpio_o, 32'h0000_004E);
      wr(4'd0, 32'hA5A5_0F0F);
      chk("T2 gpio_oe", gpio_oe, 32'hA5A5_0F0F);
      rchk("wo reads 0", 4'd3, 32'h0);
      wr(4'd2, 32'hFFFF_FFFF);
      rchk("IN write ignored", 4'd2, 32'h0);
      wr(4'd12, 32'hFFFF_FFFF);
      rchk("unmapped 0", 4'd12, 32'h0);
`ifndef GPIO_DEBOUNCE_EN
      wr(4'd10, 32'h0000_0007);
      rchk("addr10 0", 4'd10, 32'h0);
`endif

      // T3 sync latency
      gpio_i = 32'h8;
      step(L - 1);
      rchk("T3 early", 4'd2, 32'h0);
      step(1);
      rchk("T3 arrive", 4'd2, 32'h8);

      // T4 edge interrupt
      wr(4'd7, 32'h1);
      wr(4'd6, 32'h1);
      gpio_i = 32'h9;
      step(L + 1);
      rchk("T4 stat", 4'd9, 32'h1);
      chk("T4 irq lag", {31'h0, irq}, 32'h0);
      step(1);
      chk("T4 irq", {31'h0, irq}, 32'h1);
      wr(4'd9, 32'h1);
      rchk("T4 w1c", 4'd9, 32'h0);
      step(1);
      chk("T4 irq clr", {31'h0, irq}, 32'h0);
      gpio_i = 32'h8;
      step(L + 2);
      wr(4'd7, 32'h0);
      wr(4'd8, 32'h1);
      gpio_i = 32'h9;
      step(L + 3);
      rchk("T4 fall only", 4'd9, 32'h0);

      // T5 W1C collides with a new fall on pin 2
      wr(4'd8, 32'h4);
      gpio_i = 32'hD;
      step(L + 2);
      gpio_i = 32'h9;
      step(L + 1);
      rchk("T5 fall", 4'd9, 32'h4);
      gpio_i = 32'hD;
      step(L + 2);
      gpio_i = 32'h9;
      step(L);
      wr(4'd9, 32'h4);
      rchk("T5 collide", 4'd9, 32'h4);
      wr(4'd9, 32'h4);
      rchk("T5 cleared", 4'd9, 32'h0);

      // mid-operation reset, then pins already high produce a rise
      wr(4'd6, 32'hF);
      rst = 1'b0;
      #1;
      chk("mid rst o", gpio_o, 32'h0);
      chk("mid rst oe", gpio_oe, 32'h0);
      chk("mid rst irq", {31'h0, irq}, 32'h0);
      rchk("mid rst IN", 4'd2, 32'h0);
      step(1);
      rst = 1'b1;
      wr(4'd7, 32'hFF);
      step(L);
      rchk("rise after rst", 4'd9, 32'h9);

`ifdef GPIO_DEBOUNCE_EN
      // T6 debounce with prescaler
      wr(4'd10, 32'h3);
      rchk("T6 limit", 4'd10, 32'h3);
      gpio_i = 32'hB;
      step(5);
      gpio_i = 32'h9;
      step(20);
      addr = 4'd2; #1;
      chk("T6 glitch", {31'h0, rdata[1]}, 32'h0);
      gpio_i = 32'hB;
      step(16);
      addr = 4'd2; #1;
      chk("T6 held", {31'h0, rdata[1]}, 32'h1);
`endif

      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
